mcyc_ctrl: RTL
==============

MCYC_CTRL -- requirements
Module: mcyc_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports op and func, input, 6 each, opcode/function fields of the instruction register.
REQ-004 SHALL have port Zero, input, 1, ALU zero flag.
REQ-005 SHALL have ports PCWrite, IRWrite, RegWrite, MemWrite, MemtoReg, ALUsrc, RegDst, sign, Branch, PCj, jalsave, jr, sb, output, 1 each, datapath strobes/selects.
REQ-006 SHALL have port ALUControl, output, 3, ALU operation code.
REQ-007 SHALL have port state, output, 3, current FSM state for debug.
REQ-008 SHALL have port retire, output, 1, one-cycle pulse in the final cycle of each instruction.
REQ-009 SHALL have port illegal, output, 1, sticky flag set on an undecodable instruction.

Function
REQ-010 SHALL implement states FETCH, DECODE, EXEC, MEM, WB; Moore outputs decoded from state plus the latched op/func.
REQ-011 FETCH SHALL assert IRWrite=1 and go to DECODE; no other write enable.
REQ-012 DECODE SHALL latch op/func into internal registers; later states use only the latched copies.
REQ-013 Cycle counts SHALL be: addu/subu/ori/lui 4 (F,D,E,WB); lw 5 (F,D,E,M,WB); sw/sb 4 (F,D,E,M); beq 3 (F,D,E); j/jal/jr 2 (F,D).
REQ-014 EXEC SHALL drive ALUControl: add 000 for addu/lw/sw/sb, sub 001 for subu/beq, or 010 for ori, lui 011 for lui.
REQ-015 ALUsrc SHALL be 1 in EXEC/MEM/WB for ori/lui/lw/sw/sb; sign=1 only for lw/sw/sb/beq.
REQ-016 WB SHALL assert RegWrite=1 for one cycle; RegDst=1 only for R-type; MemtoReg=1 only for lw.
REQ-017 MEM SHALL assert MemWrite=1 for exactly one cycle for sw/sb; sb=1 in that cycle for sb only.
REQ-018 beq SHALL assert Branch=1 and PCWrite=1 in EXEC; the taken/not-taken choice comes from Zero in the datapath.
REQ-019 j/jal SHALL assert PCj=1 and PCWrite=1 in DECODE; jal also asserts jalsave=1 and RegWrite=1 in that cycle.
REQ-020 jr (op 000000, func 001000) SHALL assert jr=1 and PCWrite=1 in DECODE.
REQ-021 For every other instruction, PCWrite SHALL be asserted exactly once, in the final state.
REQ-022 retire SHALL equal 1 in the final state of every instruction, including illegal ones.
REQ-023 Illegal op/func SHALL complete in F,D with PCWrite=1 and no RegWrite/MemWrite, and set illegal=1 until reset.
REQ-024 op=000000, func=000000 (nop) SHALL be legal: 2 cycles, no register or memory write.
REQ-025 After every final state the next state SHALL be FETCH; states SHALL never be skipped or repeated.

Reset
REQ-026 reset=0 SHALL immediately force state=FETCH, clear latched op/func and illegal, and drive every write enable and retire to 0.
REQ-027 Reset asserted mid-instruction SHALL abort it with no further write; the first cycle after release is FETCH.

Configuration
REQ-028 With SB_EN defined, sb (op 101000) SHALL be decoded per REQ-013/017.
REQ-029 Without SB_EN, op 101000 SHALL be illegal per REQ-023; output sb SHALL be tied to 0.

Structure
REQ-030 Package mcyc_ctrl_pkg SHALL hold the state encoding, ALUControl codes, and op/func constants.
REQ-031 A combinational sub-module ctrl_decode SHALL classify latched op/func into an instruction class with a legal flag.

Verification
REQ-032 Reset released, addu (op 0, func 100001): states F,D,E,WB; RegWrite=1 and RegDst=1 only in cycle 4; retire in cycle 4.
REQ-033 lw (100011) then sw (101011): 5 cycles, then 4; MemtoReg=1 in lw WB; a single MemWrite pulse in sw MEM.
REQ-034 beq (000100) with Zero=1, then Zero=0: both 3 cycles, Branch=1 and PCWrite=1 in EXEC.
REQ-035 jal (000011): 2 cycles; PCj=1, jalsave=1, RegWrite=1, PCWrite=1 in DECODE.
REQ-036 op 101000 with SB_EN defined gives sb=1 and MemWrite=1 in cycle 4; without SB_EN it gives illegal=1, no MemWrite, and 2 cycles.
REQ-037 reset=0 asserted during lw MEM: state=FETCH asynchronously, no RegWrite is issued, and illegal is cleared.

Source files
------------

// File: rtl/mcyc_ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: FSM state encoding,
// ALU operation codes, opcode/function constants and the instruction classes.
package mcyc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_LUI = 3'b011;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_NOP  = 6'b000000;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;

  typedef enum logic [3:0] {
    C_NOP, C_ADDU, C_SUBU, C_JR, C_ORI, C_LUI, C_LW,
    C_SW, C_SB, C_BEQ, C_J, C_JAL, C_ILLEGAL
  } instr_class_e;

  // Instructions whose second ALU operand is the immediate.
  function automatic logic uses_imm(instr_class_e c);
    return (c == C_ORI) || (c == C_LUI) || (c == C_LW) || (c == C_SW) || (c == C_SB);
  endfunction

  // Instructions whose immediate is sign-extended.
  function automatic logic uses_sign(instr_class_e c);
    return (c == C_LW) || (c == C_SW) || (c == C_SB) || (c == C_BEQ);
  endfunction

endpackage

// File: rtl/mcyc_ctrl_decode.sv
// Combinational instruction classifier for the multi-cycle controller.
// The sb opcode is recognised only when SB_EN is defined.
module ctrl_decode
  import mcyc_ctrl_pkg::*;
(
  input  logic [5:0]   op,
  input  logic [5:0]   func,
  output instr_class_e cls,
  output logic         legal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    cls = C_ILLEGAL;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_NOP:  cls = C_NOP;
          FN_ADDU: cls = C_ADDU;
          FN_SUBU: cls = C_SUBU;
          FN_JR:   cls = C_JR;
          default: cls = C_ILLEGAL;
        endcase
      end
      OP_J:    cls = C_J;
      OP_JAL:  cls = C_JAL;
      OP_BEQ:  cls = C_BEQ;
      OP_ORI:  cls = C_ORI;
      OP_LUI:  cls = C_LUI;
      OP_LW:   cls = C_LW;
      OP_SW:   cls = C_SW;
`ifdef SB_EN
      OP_SB:   cls = C_SB;
`endif
      default: cls = C_ILLEGAL;
    endcase
  end

  assign legal = (cls != C_ILLEGAL);

endmodule

// File: rtl/mcyc_ctrl.sv
// Multi-cycle MIPS-style control FSM (FETCH/DECODE/EXEC/MEM/WB) with Moore outputs.
// Define SB_EN to decode the sb store-byte instruction; otherwise it is illegal.
module mcyc_ctrl
  import mcyc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       ALUsrc,
  output logic       RegDst,
  output logic       sign,
  output logic       Branch,
  output logic       PCj,
  output logic       jalsave,
  output logic       jr,
  output logic       sb,
  output logic [2:0] ALUControl,
  output logic [2:0] state,
  output logic       retire,
  output logic       illegal
);

  state_e       state_q, state_d;
  logic [5:0]   op_q, func_q;
  logic         illegal_q;
  logic [5:0]   dec_op, dec_func;
  instr_class_e cls;
  logic         legal;

  // The branch decision is resolved in the datapath, so Zero is not consumed here.
  logic unused_zero;
  assign unused_zero = Zero;

  // The IR is only valid from DECODE on; afterwards the latched copy is authoritative.
  assign dec_op   = (state_q == S_DECODE) ? op   : op_q;
  assign dec_func = (state_q == S_DECODE) ? func : func_q;

  ctrl_decode u_decode (
    .op    (dec_op),
    .func  (dec_func),
    .cls   (cls),
    .legal (legal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      func_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q   <= op;
        func_q <= func;
        if (!legal) illegal_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = S_FETCH;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    MemtoReg   = 1'b0;
    ALUsrc     = 1'b0;
    RegDst     = 1'b0;
    sign       = 1'b0;
    Branch     = 1'b0;
    PCj        = 1'b0;
    jalsave    = 1'b0;
    jr         = 1'b0;
    sb         = 1'b0;
    ALUControl = ALU_ADD;
    retire     = 1'b0;
    // Outputs are gated by reset so no strobe fires while reset is held low.
    if (reset) begin
      case (state_q)
        S_FETCH: begin
          IRWrite = 1'b1;
          state_d = S_DECODE;
        end
        S_DECODE: begin
          state_d = S_EXEC;
          case (cls)
            C_J: begin
              PCj = 1'b1; PCWrite = 1'b1; retire = 1'b1; state_d = S_FETCH;
            end
            C_JAL: begin
              PCj = 1'b1; jalsave = 1'b1; RegWrite = 1'b1;
              PCWrite = 1'b1; retire = 1'b1; state_d = S_FETCH;
            end
            C_JR: begin
              jr = 1'b1; PCWrite = 1'b1; retire = 1'b1; state_d = S_FETCH;
            end
            C_NOP, C_ILLEGAL: begin
              PCWrite = 1'b1; retire = 1'b1; state_d = S_FETCH;
            end
            default: state_d = S_EXEC;
          endcase
        end
        S_EXEC: begin
          ALUsrc  = uses_imm(cls);
          sign    = uses_sign(cls);
          state_d = S_WB;
          case (cls)
            C_SUBU: ALUControl = ALU_SUB;
            C_ORI:  ALUControl = ALU_OR;
            C_LUI:  ALUControl = ALU_LUI;
            C_LW, C_SW, C_SB: begin
              ALUControl = ALU_ADD;
              state_d    = S_MEM;
            end
            C_BEQ: begin
              ALUControl = ALU_SUB;
              Branch = 1'b1; PCWrite = 1'b1; retire = 1'b1; state_d = S_FETCH;
            end
            default: ALUControl = ALU_ADD;
          endcase
        end
        S_MEM: begin
          ALUsrc = uses_imm(cls);
          sign   = uses_sign(cls);
          if (cls == C_LW) begin
            state_d = S_WB;
          end else begin
            MemWrite = 1'b1; PCWrite = 1'b1; retire = 1'b1; state_d = S_FETCH;
`ifdef SB_EN
            sb = (cls == C_SB);
`endif
          end
        end
        S_WB: begin
          ALUsrc   = uses_imm(cls);
          sign     = uses_sign(cls);
          RegWrite = 1'b1;
          RegDst   = (cls == C_ADDU) || (cls == C_SUBU);
          MemtoReg = (cls == C_LW);
          PCWrite  = 1'b1;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;

endmodule
